// File: rtl/control_pkg.sv
// Shared types and encodings for the control sequencer: phase codes, opcodes,
// ALU selects and the per-cycle enable vector.
package control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_LOAD  = 4'b0101;
  localparam logic [3:0] OP_STORE = 4'b0110;
  localparam logic [3:0] OP_BLT   = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Single-bit enables driven to the datapath each cycle
  typedef struct packed {
    logic instr_rd;
    logic read_1;
    logic read_2;
    logic ram_rd;
    logic ram_wr;
    logic reg_wr;
    logic pc_en;
    logic pc_load;
    logic halted;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational output decoder: maps the upcoming phase, latched opcode and
// branch latch to the enable vector and ALU select registered by the top.
module control_decode
  import control_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALU_W    = 2
) (
  input  state_t              next_state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                branch_i,
  output ctrl_t               ctrl_c_o,
  output logic [ALU_W-1:0]    alu_c_o
);

  logic                legal;
  logic [OPCODE_W-1:0] op_eff;

  // Undefined opcodes behave as NOP once flagged
  always_comb begin
    legal = 1'b0;
    case (opcode_i)
      OPCODE_W'(OP_NOP), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND),
      OPCODE_W'(OP_OR), OPCODE_W'(OP_LOAD), OPCODE_W'(OP_STORE), OPCODE_W'(OP_BLT),
      OPCODE_W'(OP_HALT): legal = 1'b1;
      default:            legal = 1'b0;
    endcase
    op_eff = legal ? opcode_i : OPCODE_W'(OP_NOP);
  end

  always_comb begin
    ctrl_c_o = '0;
    alu_c_o  = '0;
    case (next_state_i)
      ST_FETCH: ctrl_c_o.instr_rd = 1'b1;
      ST_DECODE: begin
        ctrl_c_o.read_1  = 1'b1;
        ctrl_c_o.read_2  = 1'b1;
        ctrl_c_o.illegal = ~legal;
      end
      ST_EXECUTE: begin
        case (op_eff)
          OPCODE_W'(OP_ADD):                    alu_c_o = ALU_W'(ALU_ADD);
          OPCODE_W'(OP_SUB), OPCODE_W'(OP_BLT): alu_c_o = ALU_W'(ALU_SUB);
          OPCODE_W'(OP_AND):                    alu_c_o = ALU_W'(ALU_AND);
          OPCODE_W'(OP_OR):                     alu_c_o = ALU_W'(ALU_OR);
          default:                              alu_c_o = ALU_W'(ALU_ADD);
        endcase
      end
      ST_MEMORY: begin
        ctrl_c_o.ram_rd = (op_eff == OPCODE_W'(OP_LOAD));
        ctrl_c_o.ram_wr = (op_eff == OPCODE_W'(OP_STORE));
      end
      ST_WRITEBACK: begin
        ctrl_c_o.reg_wr = (op_eff == OPCODE_W'(OP_ADD)) || (op_eff == OPCODE_W'(OP_SUB)) ||
                          (op_eff == OPCODE_W'(OP_AND)) || (op_eff == OPCODE_W'(OP_OR))  ||
                          (op_eff == OPCODE_W'(OP_LOAD));
        // Taken branch loads the target instead of incrementing
        if ((op_eff == OPCODE_W'(OP_BLT)) && branch_i) begin
          ctrl_c_o.pc_load = 1'b1;
        end else begin
          ctrl_c_o.pc_en = 1'b1;
        end
      end
      ST_HALTED: ctrl_c_o.halted = 1'b1;
      default: begin
        ctrl_c_o = '0;
        alu_c_o  = '0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: owns the phase FSM, latches the opcode and
// registers datapath enables per phase. CTRL_RETIRE_COUNT_EN adds retired_count.
module control_sequencer
  import control_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALU_W    = 2,
  parameter int unsigned STATE_W  = 3
`ifdef CTRL_RETIRE_COUNT_EN
  , parameter int unsigned COUNT_W = 16
`endif
) (
  input  logic                clock,
  input  logic                control_reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                LT_flag,
  input  logic                mem_ready,
  output logic [STATE_W-1:0]  state,
  output logic [OPCODE_W-1:0] opcode_store,
  output logic [ALU_W-1:0]    alu_control,
  output logic                instr_rdEN,
  output logic                read_1EN,
  output logic                read_2EN,
  output logic                RAM_rdEN,
  output logic                RAM_wrEN,
  output logic                reg_file_wrEN,
  output logic                PC_EN,
  output logic                PC_load,
  output logic                halted,
  output logic                illegal_op
`ifdef CTRL_RETIRE_COUNT_EN
  , output logic [COUNT_W-1:0] retired_count
`endif
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_store_q, opcode_store_d;
  logic                branch_q, branch_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [ALU_W-1:0]    alu_q, alu_d;
  logic                is_mem_op;

  assign is_mem_op = (opcode_store_q == OPCODE_W'(OP_LOAD)) ||
                     (opcode_store_q == OPCODE_W'(OP_STORE));

  // Phase sequencing plus opcode and branch latches
  always_comb begin
    state_d        = state_q;
    opcode_store_d = opcode_store_q;
    branch_d       = branch_q;
    case (state_q)
      ST_FETCH: begin
        state_d        = ST_DECODE;
        opcode_store_d = opcode;
      end
      ST_DECODE: begin
        state_d = (opcode_store_q == OPCODE_W'(OP_HALT)) ? ST_HALTED : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = is_mem_op ? ST_MEMORY : ST_WRITEBACK;
        if (opcode_store_q == OPCODE_W'(OP_BLT)) begin
          branch_d = LT_flag;
        end
      end
      ST_MEMORY: begin
        if (mem_ready) begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Decoding the next phase lets the registered outputs line up with state
  control_decode #(
    .OPCODE_W (OPCODE_W),
    .ALU_W    (ALU_W)
  ) u_decode (
    .next_state_i (state_d),
    .opcode_i     (opcode_store_d),
    .branch_i     (branch_d),
    .ctrl_c_o     (ctrl_d),
    .alu_c_o      (alu_d)
  );

  always_ff @(posedge clock) begin
    if (!control_reset) begin
      state_q        <= ST_FETCH;
      opcode_store_q <= '0;
      branch_q       <= 1'b0;
      ctrl_q         <= '0;
      alu_q          <= '0;
    end else begin
      state_q        <= state_d;
      opcode_store_q <= opcode_store_d;
      branch_q       <= branch_d;
      ctrl_q         <= ctrl_d;
      alu_q          <= alu_d;
    end
  end

`ifdef CTRL_RETIRE_COUNT_EN
  logic [COUNT_W-1:0] retired_q;

  // Saturating count of completed writebacks
  always_ff @(posedge clock) begin
    if (!control_reset) begin
      retired_q <= '0;
    end else if ((state_q == ST_WRITEBACK) && (retired_q != '1)) begin
      retired_q <= retired_q + COUNT_W'(1);
    end
  end

  assign retired_count = retired_q;
`endif

  assign state         = STATE_W'(state_q);
  assign opcode_store  = opcode_store_q;
  assign alu_control   = alu_q;
  assign instr_rdEN    = ctrl_q.instr_rd;
  assign read_1EN      = ctrl_q.read_1;
  assign read_2EN      = ctrl_q.read_2;
  assign RAM_rdEN      = ctrl_q.ram_rd;
  assign RAM_wrEN      = ctrl_q.ram_wr;
  assign reg_file_wrEN = ctrl_q.reg_wr;
  assign PC_EN         = ctrl_q.pc_en;
  assign PC_load       = ctrl_q.pc_load;
  assign halted        = ctrl_q.halted;
  assign illegal_op    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed and random instructions checked cycle by
// cycle against an instruction-level reference model.
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       control_reset = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       LT_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] state;
  logic [3:0] opcode_store;
  logic [1:0] alu_control;
  logic instr_rdEN, read_1EN, read_2EN, RAM_rdEN, RAM_wrEN;
  logic reg_file_wrEN, PC_EN, PC_load, halted, illegal_op;
`ifdef CTRL_RETIRE_COUNT_EN
  logic [15:0] retired_count;
  int          exp_retired = 0;
`endif

  int vectors = 0;
  int miscompares = 0;

  control_sequencer dut (
    .clock         (clock),
    .control_reset (control_reset),
    .opcode        (opcode),
    .LT_flag       (LT_flag),
    .mem_ready     (mem_ready),
    .state         (state),
    .opcode_store  (opcode_store),
    .alu_control   (alu_control),
    .instr_rdEN    (instr_rdEN),
    .read_1EN      (read_1EN),
    .read_2EN      (read_2EN),
    .RAM_rdEN      (RAM_rdEN),
    .RAM_wrEN      (RAM_wrEN),
    .reg_file_wrEN (reg_file_wrEN),
    .PC_EN         (PC_EN),
    .PC_load       (PC_load),
    .halted        (halted),
    .illegal_op    (illegal_op)
`ifdef CTRL_RETIRE_COUNT_EN
    , .retired_count (retired_count)
`endif
  );

  always #5 clock = ~clock;

  logic [14:0] obs;
  assign obs = {state, alu_control, instr_rdEN, read_1EN, read_2EN, RAM_rdEN, RAM_wrEN,
                reg_file_wrEN, PC_EN, PC_load, halted, illegal_op};

  // Expected output vector for one phase of an instruction, straight from the opcode table
  function automatic logic [14:0] exp_vec(input int phase, input logic [3:0] op, input logic taken);
    logic [1:0] alu_tab [0:7];
    logic       wr_tab  [0:7];
    logic       legal;
    logic [3:0] eff;
    logic [1:0] alu;
    logic instr, r1, r2, rrd, rwr, rwe, pce, pcl, hlt, ill;
    alu_tab = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
    wr_tab  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    legal = (op <= 4'd7) || (op == 4'd15);
    eff   = legal ? op : 4'd0;
    {alu, instr, r1, r2, rrd, rwr, rwe, pce, pcl, hlt, ill} = '0;
    case (phase)
      0: instr = 1'b1;
      1: begin r1 = 1'b1; r2 = 1'b1; ill = ~legal; end
      2: if (eff <= 4'd7) alu = alu_tab[eff[2:0]];
      3: begin rrd = (eff == 4'd5); rwr = (eff == 4'd6); end
      4: begin
        if (eff <= 4'd7) rwe = wr_tab[eff[2:0]];
        pcl = (eff == 4'd7) && taken;
        pce = ~pcl;
      end
      5: hlt = 1'b1;
      default: ;
    endcase
    return {3'(phase), alu, instr, r1, r2, rrd, rwr, rwe, pce, pcl, hlt, ill};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [14:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_retired(input string tag);
`ifdef CTRL_RETIRE_COUNT_EN
    vectors++;
    assert (retired_count === 16'(exp_retired)) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, retired_count, exp_retired);
    end
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // Runs one instruction starting in FETCH; ends in the next FETCH (or HALTED)
  task automatic run_instr(input logic [3:0] op, input logic lt, input int nwait);
    opcode = op;
    tick();
    opcode    = 4'($urandom);
    LT_flag   = 1'($urandom);
    mem_ready = 1'($urandom);
    check("decode", exp_vec(1, op, 1'b0));
    if (op == 4'd15) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        mem_ready = 1'($urandom);
        check("halted", exp_vec(5, op, 1'b0));
      end
      return;
    end
    tick();
    check("execute", exp_vec(2, op, 1'b0));
    LT_flag = lt;
    tick();
    LT_flag = 1'($urandom);
    if (op == 4'd5 || op == 4'd6) begin
      for (int i = 0; i < nwait; i++) begin
        mem_ready = 1'b0;
        check("mem_wait", exp_vec(3, op, 1'b0));
        tick();
      end
      mem_ready = 1'b1;
      check("memory", exp_vec(3, op, 1'b0));
      tick();
    end
    mem_ready = 1'($urandom);
    check("writeback", exp_vec(4, op, lt));
    tick();
`ifdef CTRL_RETIRE_COUNT_EN
    exp_retired++;
`endif
    check("fetch", exp_vec(0, op, 1'b0));
    check_retired("retired");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [3:0] rop;
    // Reset held for two edges
    opcode = 4'($urandom);
    tick();
    tick();
    check("reset", 15'd0);
    check_retired("reset_retired");
    control_reset = 1'b1;

    run_instr(4'd0, 1'b1, 0);
    run_instr(4'd1, 1'b0, 0);
    run_instr(4'd2, 1'b1, 0);
    run_instr(4'd3, 1'b0, 0);
    run_instr(4'd4, 1'b1, 0);
    run_instr(4'd5, 1'b1, 3);
    run_instr(4'd6, 1'b1, 0);
    run_instr(4'd7, 1'b1, 0);
    run_instr(4'd7, 1'b0, 0);
    run_instr(4'b1010, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 14));
      run_instr(rop, 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset during a STORE memory wait
    opcode = 4'd6;
    tick();
    check("st_decode", exp_vec(1, 4'd6, 1'b0));
    tick();
    check("st_execute", exp_vec(2, 4'd6, 1'b0));
    mem_ready = 1'b0;
    tick();
    check("st_memory", exp_vec(3, 4'd6, 1'b0));
    control_reset = 1'b0;
    tick();
    check("st_abort", 15'd0);
    control_reset = 1'b1;
`ifdef CTRL_RETIRE_COUNT_EN
    exp_retired = 0;
`endif
    check_retired("abort_retired");
    run_instr(4'd1, 1'b0, 0);

    // HALT is sticky until reset
    run_instr(4'd15, 1'b0, 0);
    control_reset = 1'b0;
    tick();
    check("halt_reset", 15'd0);
    control_reset = 1'b1;
`ifdef CTRL_RETIRE_COUNT_EN
    exp_retired = 0;
`endif
    run_instr(4'd0, 1'b0, 0);
    run_instr(4'd4, 1'b0, 0);
    run_instr(4'd5, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
